// File: rtl/bft_stream_tx_if.sv
// bft_stream_tx_if -- 32-bit AXI-stream style handshake between a stream
// producer and the BFT transmit packetizer.
//
// Signals:
//   tdata  : stream payload
//   tvalid : producer has a beat on tdata
//   tready : packetizer can accept the beat this cycle
//
// Modports:
//   master : producer side (drives tdata/tvalid, observes tready)
//   slave  : packetizer side (observes tdata/tvalid, drives tready)

interface bft_stream_tx_if #(
   parameter int unsigned DATA_BITS = 32
) ();

   logic [DATA_BITS-1:0] tdata;
   logic                 tvalid;
   logic                 tready;

   modport master (
      output tdata,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );

endinterface

// File: rtl/bft_stream_tx.sv
// bft_stream_tx -- source-side packetizer for the BFT network.
//
// Turns a 32-bit stream into 49-bit BFT data packets aimed at one input port
// of a destination leaf, and enforces the credit protocol of that leaf's
// receive buffer: one credit per packet sent, FREESPACE_UPDATE_SIZE credits
// regained per freespace-update packet returned by the destination.
//
// Packet layout: [48] valid | [47:44] leaf | [43:40] port | [39:33] addr |
//                [32] freespace flag (0 = data) | [31:0] payload
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   cfg_dest_leaf     : destination leaf, sampled per packet
//   cfg_dest_port     : destination input port (0 is reserved -> stall)
//   din               : stream input (slave side of bft_stream_tx_if)
//   din_leaf_bft2tx   : packets from the network (only updates consumed)
//   dout_leaf_tx2bft  : registered packets to the network, all-zero = idle
//   credit_count      : current credits, 0..2^NUM_BRAM_ADDR_BITS

module bft_stream_tx #(
   parameter int unsigned PACKET_BITS           = 49,
   parameter int unsigned PAYLOAD_BITS          = 32,
   parameter int unsigned NUM_LEAF_BITS         = 4,
   parameter int unsigned NUM_PORT_BITS         = 4,
   parameter int unsigned NUM_ADDR_BITS         = 7,
   parameter int unsigned NUM_BRAM_ADDR_BITS    = 7,
   parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
   parameter int unsigned SRC_LEAF              = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_LEAF_BITS-1:0]      cfg_dest_leaf,
   input  logic [NUM_PORT_BITS-1:0]      cfg_dest_port,
   bft_stream_tx_if.slave                din,
   input  logic [PACKET_BITS-1:0]        din_leaf_bft2tx,
   output logic [PACKET_BITS-1:0]        dout_leaf_tx2bft,
   output logic [NUM_BRAM_ADDR_BITS:0]   credit_count
);

   localparam int unsigned CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;

   // Field positions, derived top-down from the valid bit.
   localparam int unsigned VALID_BIT = PACKET_BITS - 1;
   localparam int unsigned LEAF_LSB  = VALID_BIT - NUM_LEAF_BITS;
   localparam int unsigned PORT_LSB  = LEAF_LSB - NUM_PORT_BITS;
   localparam int unsigned FLAG_BIT  = PAYLOAD_BITS;

   localparam logic [CREDIT_BITS-1:0] CREDIT_INIT =
      CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);
   localparam logic [CREDIT_BITS:0]   CREDIT_MAX_W =
      (CREDIT_BITS+1)'(1 << NUM_BRAM_ADDR_BITS);
   localparam logic [CREDIT_BITS:0]   UPDATE_INC =
      (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_STALL
   } state_t;

   state_t                   r_state;
   logic [CREDIT_BITS-1:0]   r_credit;
   logic [NUM_ADDR_BITS-1:0] r_addr;
   logic [PACKET_BITS-1:0]   r_dout;

   logic                     w_tready;
   logic                     w_accept;
   logic                     w_update;
   logic [CREDIT_BITS:0]     w_credit_sum;
   logic [CREDIT_BITS-1:0]   w_credit_next;
   logic                     w_unused_rx;

   // Ready depends only on registered state/credit plus the static port
   // configuration, never on tvalid.
   always_comb begin
      w_tready = (r_state == S_RUN) && (r_credit != '0) && (cfg_dest_port != '0);
      w_accept = din.tvalid && w_tready;
   end

   always_comb begin
      w_update = din_leaf_bft2tx[VALID_BIT]
              && (din_leaf_bft2tx[VALID_BIT-1:LEAF_LSB] == NUM_LEAF_BITS'(SRC_LEAF))
              && (din_leaf_bft2tx[LEAF_LSB-1:PORT_LSB] == '0)
              && din_leaf_bft2tx[FLAG_BIT];
   end

   // One extra bit of headroom so a send and an update in the same cycle are
   // summed before saturating at the buffer depth.
   always_comb begin
      w_credit_sum = {1'b0, r_credit};
      if (w_update)
         w_credit_sum = w_credit_sum + UPDATE_INC;
      if (w_accept)
         w_credit_sum = w_credit_sum - 1'b1;
      if (w_credit_sum > CREDIT_MAX_W)
         w_credit_next = CREDIT_INIT;
      else
         w_credit_next = w_credit_sum[CREDIT_BITS-1:0];
   end

   // Address/payload bits of incoming packets carry no meaning here.
   assign w_unused_rx = ^{din_leaf_bft2tx[PORT_LSB-1:FLAG_BIT+1],
                          din_leaf_bft2tx[FLAG_BIT-1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_INIT;
         r_credit <= CREDIT_INIT;
         r_addr   <= '0;
         r_dout   <= '0;
      end else begin
         r_credit <= w_credit_next;
         if (w_accept) begin
            r_dout <= {1'b1, cfg_dest_leaf, cfg_dest_port, r_addr, 1'b0, din.tdata};
            r_addr <= r_addr + 1'b1;
         end else begin
            r_dout <= '0;
         end
         case (r_state)
            S_INIT:  r_state <= S_RUN;
            default: r_state <= (w_credit_next == '0) ? S_STALL : S_RUN;
         endcase
      end
   end

   assign din.tready       = w_tready;
   assign dout_leaf_tx2bft = r_dout;
   assign credit_count     = r_credit;

endmodule

// File: tb/tb_bft_stream_tx.sv
// tb_bft_stream_tx -- randomized and directed self-checking bench for
// bft_stream_tx against a credit/sequence reference model.

module tb_bft_stream_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  cfg_dest_leaf;
   logic [3:0]  cfg_dest_port;
   logic [48:0] din_leaf_bft2tx;
   logic [48:0] dout_leaf_tx2bft;
   logic [7:0]  credit_count;

   always #5 clk = ~clk;

   bft_stream_tx_if #(.DATA_BITS(32)) u_if ();

   bft_stream_tx #(
      .PACKET_BITS           (49),
      .PAYLOAD_BITS          (32),
      .NUM_LEAF_BITS         (4),
      .NUM_PORT_BITS         (4),
      .NUM_ADDR_BITS         (7),
      .NUM_BRAM_ADDR_BITS    (7),
      .FREESPACE_UPDATE_SIZE (64),
      .SRC_LEAF              (0)
   ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .cfg_dest_leaf    (cfg_dest_leaf),
      .cfg_dest_port    (cfg_dest_port),
      .din              (u_if),
      .din_leaf_bft2tx  (din_leaf_bft2tx),
      .dout_leaf_tx2bft (dout_leaf_tx2bft),
      .credit_count     (credit_count)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: credits as a plain integer, sequence number as a
   // modulo-128 counter, and a flag for the single post-reset idle cycle.
   int          m_credit = 128;
   int          m_addr   = 0;
   bit          m_init   = 1'b1;
   bit          m_known  = 1'b0;
   logic [48:0] m_dout   = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_update(input logic [48:0] p);
      return p[48] && (p[47:44] == 4'd0) && (p[43:40] == 4'd0) && p[32];
   endfunction

   // One clock cycle with the inputs the caller has already set.
   task automatic step();
      bit exp_rdy;
      bit acc;
      #1;
      exp_rdy = !m_init && (m_credit != 0) && (cfg_dest_port != 4'd0);
      if (m_known)
         check("tready", {63'd0, u_if.tready}, {63'd0, exp_rdy});
      acc = m_known && u_if.tvalid && exp_rdy;
      if (reset) begin
         m_credit = 128;
         m_addr   = 0;
         m_init   = 1'b1;
         m_dout   = '0;
         m_known  = 1'b1;
      end else begin
         m_dout = acc ? {1'b1, cfg_dest_leaf, cfg_dest_port, 7'(m_addr), 1'b0, u_if.tdata}
                      : 49'd0;
         m_credit = m_credit - int'(acc) + (is_update(din_leaf_bft2tx) ? 64 : 0);
         if (m_credit > 128)
            m_credit = 128;
         if (acc)
            m_addr = (m_addr + 1) % 128;
         m_init = 1'b0;
      end
      @(posedge clk);
      #1;
      if (m_known) begin
         check("dout", {15'd0, dout_leaf_tx2bft}, {15'd0, m_dout});
         check("credit", {56'd0, credit_count}, 64'(m_credit));
      end
   endtask

   task automatic beat(input logic [31:0] data);
      u_if.tvalid = 1'b1;
      u_if.tdata  = data;
      step();
   endtask

   task automatic update_pkt(output logic [48:0] p);
      p = {1'b1, 4'd0, 4'd0, 7'($urandom), 1'b1, 32'($urandom)};
   endtask

   initial begin
      logic [48:0] pkt;
      logic [63:0] rnd;
      logic [48:0] nonmatch [4];
      int          upd_pct;

      reset           = 1'b1;
      u_if.tvalid     = 1'b0;
      u_if.tdata      = '0;
      cfg_dest_leaf   = 4'd2;
      cfg_dest_port   = 4'd1;
      din_leaf_bft2tx = '0;

      step();
      step();
      check("rst_credit", {56'd0, credit_count}, 64'd128);
      check("rst_dout", {15'd0, dout_leaf_tx2bft}, 64'd0);
      check("rst_tready", {63'd0, u_if.tready}, 64'd0);
      reset = 1'b0;
      step();

      // Three-beat burst to leaf 2 / port 1.
      for (int i = 1; i <= 3; i++) begin
         beat(32'hA000_0000 + 32'(i));
         check("burst_pkt", {15'd0, dout_leaf_tx2bft},
               {15'd0, 1'b1, 4'd2, 4'd1, 7'(i - 1), 1'b0, 32'hA000_0000 + 32'(i)});
      end
      check("burst_credit", {56'd0, credit_count}, 64'd125);

      // Drain the remaining credits; last packet carries addr 127.
      for (int i = 0; i < 125; i++)
         beat($urandom);
      check("last_addr", {57'd0, dout_leaf_tx2bft[39:33]}, 64'd127);
      check("drained", {56'd0, credit_count}, 64'd0);
      beat($urandom);
      beat($urandom);

      // One update from zero credit, then 64 more packets.
      update_pkt(pkt);
      din_leaf_bft2tx = pkt;
      u_if.tvalid     = 1'b1;
      step();
      din_leaf_bft2tx = '0;
      check("upd_credit", {56'd0, credit_count}, 64'd64);
      for (int i = 0; i < 64; i++)
         beat($urandom);
      check("restall", {56'd0, credit_count}, 64'd0);
      beat($urandom);

      // Saturation and coincident send+update.
      u_if.tvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         update_pkt(pkt);
         din_leaf_bft2tx = pkt;
         step();
      end
      din_leaf_bft2tx = '0;
      for (int i = 0; i < 28; i++)
         beat($urandom);
      check("at100", {56'd0, credit_count}, 64'd100);
      update_pkt(pkt);
      din_leaf_bft2tx = pkt;
      beat($urandom);
      din_leaf_bft2tx = '0;
      check("sat128", {56'd0, credit_count}, 64'd128);
      for (int i = 0; i < 118; i++)
         beat($urandom);
      update_pkt(pkt);
      din_leaf_bft2tx = pkt;
      beat($urandom);
      din_leaf_bft2tx = '0;
      check("at10_upd", {56'd0, credit_count}, 64'd73);

      // Packets that must not be taken as updates.
      nonmatch[0] = {1'b1, 4'd3, 4'd0, 7'd5, 1'b1, 32'h1234_5678};
      nonmatch[1] = {1'b1, 4'd0, 4'd2, 7'd5, 1'b1, 32'h1234_5678};
      nonmatch[2] = {1'b1, 4'd0, 4'd0, 7'd5, 1'b0, 32'h1234_5678};
      nonmatch[3] = {1'b0, 4'd0, 4'd0, 7'd5, 1'b1, 32'h1234_5678};
      u_if.tvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din_leaf_bft2tx = nonmatch[i];
         step();
         check("nonmatch", {56'd0, credit_count}, 64'd73);
      end
      din_leaf_bft2tx = '0;

      // Reserved port 0 holds the stream off.
      cfg_dest_port = 4'd0;
      beat($urandom);
      beat($urandom);
      cfg_dest_port = 4'd1;

      // Reset in the middle of a burst at credit 90 / addr 38.
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      for (int i = 0; i < 38; i++)
         beat($urandom);
      check("mid_credit", {56'd0, credit_count}, 64'd90);
      reset       = 1'b1;
      u_if.tvalid = 1'b1;
      step();
      check("mid_rst_dout", {15'd0, dout_leaf_tx2bft}, 64'd0);
      check("mid_rst_rdy", {63'd0, u_if.tready}, 64'd0);
      reset = 1'b0;
      step();
      beat(32'hCAFE_0001);
      check("post_rst_addr", {57'd0, dout_leaf_tx2bft[39:33]}, 64'd0);
      check("post_rst_credit", {56'd0, credit_count}, 64'd127);

      // Randomized traffic.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         upd_pct       = (cyc < 2000) ? 2 : 15;
         reset         = ($urandom_range(0, 299) == 0);
         u_if.tvalid   = ($urandom_range(0, 9) < 7);
         u_if.tdata    = $urandom;
         cfg_dest_leaf = 4'($urandom);
         cfg_dest_port = 4'($urandom);
         rnd           = {$urandom, $urandom};
         if ($urandom_range(0, 99) < upd_pct) begin
            update_pkt(pkt);
            din_leaf_bft2tx = pkt;
         end else if ($urandom_range(0, 9) < 3) begin
            update_pkt(pkt);
            case ($urandom_range(0, 2))
               0:       pkt[47:44] = 4'($urandom_range(1, 15));
               1:       pkt[43:40] = 4'($urandom_range(1, 15));
               default: pkt[32]    = 1'b0;
            endcase
            din_leaf_bft2tx = pkt;
         end else begin
            din_leaf_bft2tx = rnd[48:0];
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/bft_stream_tx.md
Name: bft_stream_tx

Overview:
- Source-side packetizer for the BFT network: accepts a 32-bit AXI-stream from a producer (host DMA or upstream kernel) and emits 49-bit BFT packets addressed to one input port of a destination leaf.
- Enforces the credit protocol implied by the destination leaf's receive BRAM: sends only while credits remain, and regains credits from freespace-update packets returned by the destination.
- Counterpart of the leaf's receive path. Sits between a stream producer and a BFT root/leaf port.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, payload/stream width.
- NUM_LEAF_BITS, 4, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, write-address (sequence) field width.
- NUM_BRAM_ADDR_BITS, 7, depth log2 of the destination receive buffer; initial credits = 2^NUM_BRAM_ADDR_BITS = 128.
- FREESPACE_UPDATE_SIZE, 64, credits returned per freespace-update packet.
- SRC_LEAF, 0, leaf number of this transmitter, used to match returning updates.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- cfg_dest_leaf, in, 4, destination leaf; sampled every packet.
- cfg_dest_port, in, 4, destination input port; 0 is reserved.
- din_tdata, in, 32, stream payload.
- din_tvalid, in, 1, stream valid.
- din_tready, out, 1, stream ready.
- din_leaf_bft2tx, in, 49, packets from the network; only freespace updates are consumed.
- dout_leaf_tx2bft, out, 49, packets to the network. Bit 48 is the valid bit; all-zero means idle.
- credit_count, out, 8, current credits (debug/status).

Behaviour:
- Packet format:
  - [48] valid
  - [47:44] leaf
  - [43:40] port
  - [39:33] addr
  - [32] freespace flag (0 = data)
  - [31:0] payload
- Reset (synchronous, takes effect at the next edge, including mid-transfer):
  - dout = 0, din_tready = 0, credit = 128, addr = 0, state = INIT.
  - Any in-flight packet is abandoned; no partial packet is emitted.
- FSM states:
  - INIT: one cycle after reset, then → RUN.
  - RUN: din_tready = 1 when credit ≠ 0.
    - On din_tvalid & din_tready, the registered dout on the next cycle is {1, cfg_dest_leaf, cfg_dest_port, addr, 0, din_tdata}.
    - addr increments modulo 128 (127 → 0). Credit decrements.
    - If credit becomes 0 → STALL.
  - STALL: din_tready = 0, dout valid = 0. When credit becomes > 0 → RUN; tready reasserts on the cycle after the update is registered.
- Latency: one cycle from the accepting handshake to dout.
- Throughput: one packet per cycle. Without an accepted beat, dout is driven to 0 (valid low) the following cycle.
- din_tready is combinational on registered credit/state only; it never depends on din_tvalid.
- Freespace update detection:
  - Condition: din[48] = 1, din[47:44] = SRC_LEAF, din[43:40] = 0, din[32] = 1.
  - Action: credit += FREESPACE_UPDATE_SIZE, saturating at 128. Other incoming packets are ignored.
- Simultaneous send and update in the same cycle: credit_next = min(128, credit − 1 + 64).
- Credit width: 8 bits, holding 0..128. It never underflows because tready is gated by credit ≠ 0.
- Never emits a packet with port 0. If cfg_dest_port = 0, din_tready is held 0 (configuration error stall).
- Ordering: payloads leave in acceptance order with consecutive addr values. The destination uses addr as its BRAM write index.

Test Plan:
- Reset, then drive 3 beats 0xA0000001..0xA0000003 with dest leaf 2, port 1 → dout = {1,2,1,addr 0/1/2,0,payload} on consecutive cycles; credit_count reads 125.
- Stream 128 beats back-to-back with no updates → exactly 128 packets, addr wraps 127 → 0 on the last; din_tready drops on the cycle after the 128th accept; credit 0; dout idle thereafter.
- From credit 0, inject one freespace update {1,SRC_LEAF,0,x,1,x} → credit 64, tready high one cycle later, 64 more packets accepted, then stall again.
- Update coincident with a send at credit 100 → credit 128 (saturated); at credit 10 → 73.
- Non-matching packets (wrong leaf, port ≠ 0, or flag = 0) on din_leaf_bft2tx → credit unchanged.
- Assert reset mid-burst at credit 90/addr 38 → next cycle dout = 0, tready = 0; after INIT, credit 128 and the first packet carries addr 0.
